// File: rtl/pipeline_hazard_ctl.sv
// Hazard and sequencing control for a 5-stage RV32I pipeline: load-use stalls,
// EX operand forwarding selects, redirect squashes and ECALL/EBREAK halt.
module pipeline_hazard_ctl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_redirect,
    input  logic        resume,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_if_id,
    output logic        bubble_ex,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        halted
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;

    // Scoreboard: only EX and MEM entries are kept because forwarding is registered
    // at issue, so the producer a consumer sees in WB was in MEM when it issued.
    logic       r_ex_vld, r_ex_ld, r_mem_vld;
    logic [4:0] r_ex_rd, r_mem_rd;
    logic [1:0] r_fwd_a, r_fwd_b;

    logic [6:0] w_opcode;
    logic [4:0] w_rs1, w_rs2, w_rd;
    logic       w_use_rs1, w_use_rs2, w_wr_rd, w_is_load, w_is_halt;
    logic       w_ex_hit_a, w_ex_hit_b, w_mem_hit_a, w_mem_hit_b;
    logic       w_load_use, w_issue;
    logic       w_stall, w_flush, w_bubble, w_halted;
    logic       w_unused_funct3;

    assign w_opcode        = id_instr[6:0];
    assign w_rd            = id_instr[11:7];
    assign w_rs1           = id_instr[19:15];
    assign w_rs2           = id_instr[24:20];
    assign w_unused_funct3 = &{1'b0, id_instr[14:12]};

    assign w_use_rs1 = w_opcode inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_OPIMM, OP_OP};
    assign w_use_rs2 = w_opcode inside {OP_BRANCH, OP_STORE, OP_OP};
    assign w_wr_rd   = (w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP})
                       && (w_rd != 5'd0);
    assign w_is_load = (w_opcode == OP_LOAD);
    assign w_is_halt = (w_opcode == OP_SYSTEM)
                       && ((id_instr[31:20] == 12'h000) || (id_instr[31:20] == 12'h001));

    // Entries are only valid for rd != x0, so x0 can never match here.
    assign w_ex_hit_a  = w_use_rs1 && r_ex_vld  && (r_ex_rd  == w_rs1);
    assign w_ex_hit_b  = w_use_rs2 && r_ex_vld  && (r_ex_rd  == w_rs2);
    assign w_mem_hit_a = w_use_rs1 && r_mem_vld && (r_mem_rd == w_rs1);
    assign w_mem_hit_b = w_use_rs2 && r_mem_vld && (r_mem_rd == w_rs2);

    assign w_load_use = id_valid && r_ex_ld && (w_ex_hit_a || w_ex_hit_b);

    function automatic logic [1:0] fwd_src(input logic ex_hit, input logic ex_ld, input logic mem_hit);
        if (ex_hit && !ex_ld) return 2'b01;
        if (mem_hit)          return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_halted    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ex_redirect) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = FLUSH_RELOAD;
                    end
                end else if (w_load_use) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (id_valid) begin
                    w_issue = 1'b1;
                    if (w_is_halt) w_state_nxt = ST_HALT;
                end
            end
            ST_FLUSH: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                if (ex_redirect) begin
                    w_cnt_nxt = FLUSH_RELOAD;
                end else if (r_cnt <= 3'd1) begin
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_HALT: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                w_halted = 1'b1;
                if (resume) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_vld  <= 1'b0;
            r_ex_ld   <= 1'b0;
            r_mem_vld <= 1'b0;
            r_fwd_a   <= 2'b00;
            r_fwd_b   <= 2'b00;
        end else begin
            r_ex_vld  <= w_issue && w_wr_rd;
            r_ex_ld   <= w_issue && w_wr_rd && w_is_load;
            r_mem_vld <= r_ex_vld;
            r_fwd_a   <= w_issue ? fwd_src(w_ex_hit_a, r_ex_ld, w_mem_hit_a) : 2'b00;
            r_fwd_b   <= w_issue ? fwd_src(w_ex_hit_b, r_ex_ld, w_mem_hit_b) : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        r_ex_rd  <= w_rd;
        r_mem_rd <= r_ex_rd;
    end

    assign stall_if    = w_stall;
    assign stall_id    = w_stall;
    assign flush_if_id = w_flush;
    assign bubble_ex   = w_bubble;
    assign halted      = w_halted;
    assign fwd_a_sel   = r_fwd_a;
    assign fwd_b_sel   = r_fwd_b;

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed vector bench for pipeline_hazard_ctl (FLUSH_CYCLES=2).
module tb_pipeline_hazard_ctl;

    localparam logic [31:0] LW5     = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD6_52 = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] ADD6_25 = 32'h00510333; // add  x6,x2,x5
    localparam logic [31:0] ADDI3_1 = 32'h00100193; // addi x3,x0,1
    localparam logic [31:0] ADDI3_2 = 32'h00200193; // addi x3,x0,2
    localparam logic [31:0] ADD4_33 = 32'h00318233; // add  x4,x3,x3
    localparam logic [31:0] ADD6_44 = 32'h00420333; // add  x6,x4,x4
    localparam logic [31:0] SUB7_33 = 32'h403183B3; // sub  x7,x3,x3
    localparam logic [31:0] ADDI0_5 = 32'h00500013; // addi x0,x0,5
    localparam logic [31:0] ADD1_00 = 32'h000000B3; // add  x1,x0,x0
    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ECALL   = 32'h00000073;
    localparam logic [31:0] EBREAK  = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_redirect;
    logic        resume;
    logic        stall_if, stall_id, flush_if_id, bubble_ex, halted;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        redir;
        logic        res;
        logic        stall;
        logic        flush;
        logic        bubble;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        halt;
    } vec_t;

    vec_t tbl[33];
    int   n_vec = 0;

    pipeline_hazard_ctl #(.FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .ex_redirect (ex_redirect),
        .resume      (resume),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_if_id (flush_if_id),
        .bubble_ex   (bubble_ex),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic v, input logic [31:0] ins, input logic rd, input logic rs,
                           input logic s, input logic f, input logic b,
                           input logic [1:0] fa, input logic [1:0] fb, input logic h);
        tbl[n_vec] = '{v, ins, rd, rs, s, f, b, fa, fb, h};
        n_vec++;
    endtask

    task automatic check(input string name, input logic s, input logic f, input logic b,
                         input logic [1:0] fa, input logic [1:0] fb, input logic h);
        logic [8:0] got, exp;
        got = {stall_if, stall_id, flush_if_id, bubble_ex, fwd_a_sel, fwd_b_sel, halted};
        exp = {s, s, f, b, fa, fb, h};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got {stall_if,stall_id,flush,bubble,fwd_a,fwd_b,halted}=%b expected=%b",
                     name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rd, input logic rs);
        @(negedge clk);
        id_valid    = v;
        id_instr    = ins;
        ex_redirect = rd;
        resume      = rs;
        #2;
    endtask

    initial begin
        rst = 1'b0; id_valid = 1'b0; id_instr = '0; ex_redirect = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk);
        #2 check("reset_state", 0, 0, 0, 2'b00, 2'b00, 0);
        rst = 1'b1;

        // Each row: inputs this cycle, comb outputs this cycle, fwd of the instr issued last cycle.
        add_vec(1, LW5,     0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_52, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_52, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, NOP,     0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        add_vec(1, ADDI3_1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADD4_33, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADDI3_1, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0);
        add_vec(1, NOP,     0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, SUB7_33, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADDI0_5, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0);
        add_vec(1, ADD1_00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADDI3_1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADDI3_2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADD4_33, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(0, 32'h0,   0, 0, 0, 0, 0, 2'b01, 2'b01, 0);
        add_vec(1, LW5,     0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, NOP,     0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_52, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(0, 32'h0,   0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
        add_vec(1, LW5,     0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_25, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_25, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(0, 32'h0,   0, 0, 0, 0, 0, 2'b00, 2'b10, 0);
        add_vec(1, LW5,     0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_52, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        add_vec(1, ADD6_52, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        add_vec(1, ADD1_00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(0, 32'h0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(1, NOP,     1, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        add_vec(1, NOP,     1, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        add_vec(1, NOP,     0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        add_vec(1, NOP,     0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        add_vec(0, 32'h0,   0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].vld, tbl[i].instr, tbl[i].redir, tbl[i].res);
            check($sformatf("vec[%0d]", i), tbl[i].stall, tbl[i].flush, tbl[i].bubble,
                  tbl[i].fa, tbl[i].fb, tbl[i].halt);
        end

        // ECALL halt, held 10 cycles with one ignored redirect, then resume.
        drive(1, ECALL, 0, 0);
        check("ecall_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, ADD4_33, (i == 4), 0);
            check($sformatf("halt_hold[%0d]", i), 1, 0, 1, 2'b00, 2'b00, 1);
        end
        drive(1, ADD4_33, 0, 1);
        check("halt_resume_cycle", 1, 0, 1, 2'b00, 2'b00, 1);
        drive(1, ADD4_33, 0, 0);
        check("post_resume_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        drive(1, ADD6_44, 0, 0);
        check("post_resume_next", 0, 0, 0, 2'b00, 2'b00, 0);
        drive(0, 32'h0, 0, 0);
        check("post_resume_fwd", 0, 0, 0, 2'b01, 2'b01, 0);

        // Asynchronous reset in the middle of a flush.
        drive(1, NOP, 1, 0);
        check("flush_start", 0, 1, 1, 2'b00, 2'b00, 0);
        @(negedge clk);
        id_valid = 1'b1; id_instr = NOP; ex_redirect = 1'b0; resume = 1'b0;
        #1 check("mid_flush_pre", 0, 1, 1, 2'b00, 2'b00, 0);
        #1 rst = 1'b0;
        #1 check("mid_flush_rst", 0, 0, 0, 2'b00, 2'b00, 0);
        #1 rst = 1'b1;
        drive(1, NOP, 0, 0);
        check("post_flush_rst", 0, 0, 0, 2'b00, 2'b00, 0);

        // Asynchronous reset while halted, with addi x3 still in MEM.
        drive(1, ADDI3_1, 0, 0);
        check("pre_halt_addi", 0, 0, 0, 2'b00, 2'b00, 0);
        drive(1, EBREAK, 0, 0);
        check("ebreak_issue", 0, 0, 0, 2'b00, 2'b00, 0);
        @(negedge clk);
        id_valid = 1'b1; id_instr = ADD4_33; ex_redirect = 1'b0; resume = 1'b0;
        #1 check("mid_halt_pre", 1, 0, 1, 2'b00, 2'b00, 1);
        #1 rst = 1'b0;
        #1 check("mid_halt_rst", 0, 0, 0, 2'b00, 2'b00, 0);
        #1 rst = 1'b1;
        drive(0, 32'h0, 0, 0);
        check("post_rst_add_fwd", 0, 0, 0, 2'b00, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
